// File: rtl/sync_fifo_ex.sv
// rtl/sync_fifo_ex.sv - single-clock FIFO with occupancy flags and sticky error flags
// Define SYNC_FIFO_EX_FWFT_EN for first-word-fall-through; default is standard registered read.
module sync_fifo_ex #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             rvalid_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             afull_o,
   output logic             aempty_o,
   output logic [CW-1:0]    elements_o,
   output logic             ovf_o,
   output logic             udf_o,
   input  logic             clr_err_i
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr, rptr, wptr_n, rptr_n;
   logic             rd_acc, wr_acc;

   assign full_o   = (elements_o == CW'(DEPTH));
   assign empty_o  = (elements_o == '0);
   assign afull_o  = (elements_o >= CW'(AFULL_TH));
   assign aempty_o = (elements_o <= CW'(AEMPTY_TH));

   always_comb begin
      rd_acc = rd_en_i && !empty_o;
      wr_acc = wr_en_i && (!full_o || rd_acc);
      wptr_n = (wptr == LAST_IDX) ? '0 : wptr + PW'(1);
      rptr_n = (rptr == LAST_IDX) ? '0 : rptr + PW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_acc) begin
         mem[wptr] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr       <= '0;
         rptr       <= '0;
         elements_o <= '0;
      end else begin
         if (wr_acc) wptr <= wptr_n;
         if (rd_acc) rptr <= rptr_n;
         case ({wr_acc, rd_acc})
            2'b10:   elements_o <= elements_o + CW'(1);
            2'b01:   elements_o <= elements_o - CW'(1);
            default: elements_o <= elements_o;
         endcase
      end
   end

   // A set condition in the same cycle as clr_err_i takes priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         if (wr_en_i && !wr_acc) ovf_o <= 1'b1;
         else if (clr_err_i)     ovf_o <= 1'b0;
         if (rd_en_i && !rd_acc) udf_o <= 1'b1;
         else if (clr_err_i)     udf_o <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_EX_FWFT_EN
   // rdata_o is a registered copy of the head; when the head slot is the one
   // being written this cycle, bypass from wdata_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (rd_acc) begin
         if (elements_o == CW'(1)) rdata_o <= wdata_i;
         else                      rdata_o <= mem[rptr_n];
      end else if (empty_o && wr_acc) begin
         rdata_o <= wdata_i;
      end
   end

   assign rvalid_o = !empty_o;
`else
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
      end else begin
         rvalid_o <= rd_acc;
         if (rd_acc) rdata_o <= mem[rptr];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ex.sv
// tb/tb_sync_fifo_ex.sv - queue-model checker for sync_fifo_ex (DEPTH=5, WIDTH=8)
module tb_sync_fifo_ex;

   localparam int W = 8;
   localparam int D = 5;
   localparam int AF = D - 2;
   localparam int AE = 2;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  wdata = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [W-1:0]  rdata;
   logic          rvalid, full, empty, afull, aempty, ovf, udf;
   logic [CW-1:0] elements;

   int total = 0;
   int bad = 0;
   bit checking = 1'b0;

   sync_fifo_ex #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
      .rdata_o(rdata), .rvalid_o(rvalid), .full_o(full), .empty_o(empty),
      .afull_o(afull), .aempty_o(aempty), .elements_o(elements),
      .ovf_o(ovf), .udf_o(udf), .clr_err_i(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of words plus the visible read-side registers.
   logic [W-1:0] q[$];
   logic [W-1:0] m_rdata = '0;
   bit m_rvalid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
   bit rd_ok, wr_ok;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_rdata = '0;
         m_rvalid = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         rd_ok = rd_en && (q.size() > 0);
         wr_ok = wr_en && ((q.size() < D) || rd_ok);
         if (wr_en && !wr_ok) m_ovf = 1'b1;
         else if (clr_err)    m_ovf = 1'b0;
         if (rd_en && !rd_ok) m_udf = 1'b1;
         else if (clr_err)    m_udf = 1'b0;
`ifdef SYNC_FIFO_EX_FWFT_EN
         if (rd_ok) void'(q.pop_front());
         if (wr_ok) q.push_back(wdata);
         m_rvalid = (q.size() > 0);
         if (q.size() > 0) m_rdata = q[0];
`else
         m_rvalid = rd_ok;
         if (rd_ok) m_rdata = q.pop_front();
         if (wr_ok) q.push_back(wdata);
`endif
      end
   end

   always @(posedge clk) begin
      #1;
      if (checking) begin
         check("elements", int'(elements), q.size());
         check("full", int'(full), int'(q.size() == D));
         check("empty", int'(empty), int'(q.size() == 0));
         check("afull", int'(afull), int'(q.size() >= AF));
         check("aempty", int'(aempty), int'(q.size() <= AE));
         check("rvalid", int'(rvalid), int'(m_rvalid));
         check("ovf", int'(ovf), int'(m_ovf));
         check("udf", int'(udf), int'(m_udf));
`ifdef SYNC_FIFO_EX_FWFT_EN
         if (m_rvalid) check("rdata", int'(rdata), int'(m_rdata));
`else
         check("rdata", int'(rdata), int'(m_rdata));
`endif
      end
   end

   task automatic cyc(input bit w, input bit r, input logic [W-1:0] d,
                      input bit c = 1'b0, input bit rs = 1'b0);
      wr_en = w;
      rd_en = r;
      wdata = d;
      clr_err = c;
      rst = rs;
      @(posedge clk);
      #2;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr_err = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] exp_rd [7];
      exp_rd = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd11, 8'd12};
      checking = 1'b1;
      cyc(1, 1, 8'hFF, 1, 1);
      cyc(0, 0, 8'h00, 0, 1);
      check("rst_elements", int'(elements), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_aempty", int'(aempty), 1);
      check("rst_rdata", int'(rdata), 0);

      for (int i = 1; i <= D; i++) cyc(1, 0, W'(i));
      check("fill_full", int'(full), 1);
      check("fill_elements", int'(elements), 5);
      check("fill_afull", int'(afull), 1);
      cyc(1, 0, 8'd6);
      check("ovf_set", int'(ovf), 1);
      check("ovf_count", int'(elements), 5);
      cyc(0, 0, 8'd0, 1);
      check("ovf_clr", int'(ovf), 0);

      for (int i = 0; i < 7; i++) begin
         cyc(0, 1, 8'd0);
`ifndef SYNC_FIFO_EX_FWFT_EN
         check("wrap_rdata", int'(rdata), int'(exp_rd[i]));
`endif
         cyc(1, 0, W'(11 + i));
      end
      check("wrap_full", int'(full), 1);

      cyc(1, 1, 8'd99);
      check("fullrw_elements", int'(elements), 5);
      check("fullrw_ovf", int'(ovf), 0);

      for (int i = 0; i < D; i++) cyc(0, 1, 8'd0);
      cyc(0, 1, 8'd0);
      check("udf_set", int'(udf), 1);
      check("udf_rvalid", int'(rvalid), 0);
      cyc(0, 0, 8'd0, 1);
      check("udf_clr", int'(udf), 0);

      cyc(1, 1, 8'h33);
      check("emptyrw_elements", int'(elements), 1);
      cyc(1, 0, 8'h34);
      cyc(1, 0, 8'h35);
      cyc(0, 0, 8'd0, 0, 1);
      check("midrst_elements", int'(elements), 0);
      check("midrst_empty", int'(empty), 1);
      check("midrst_rdata", int'(rdata), 0);
`ifdef SYNC_FIFO_EX_FWFT_EN
      cyc(1, 0, 8'hA5);
      check("fwft_rdata", int'(rdata), 8'hA5);
      check("fwft_rvalid", int'(rvalid), 1);
      cyc(0, 1, 8'd0);
      check("fwft_pop_empty", int'(empty), 1);
`else
      cyc(1, 0, 8'h5A);
      cyc(0, 1, 8'd0);
      check("postrst_rdata", int'(rdata), 8'h5A);
      check("postrst_rvalid", int'(rvalid), 1);
`endif
      cyc(0, 0, 8'd0);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
